// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group resolves per stage.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  // Stage i holds the beat about to resolve group i.
  // Stage NG is the output register.
  logic             vld_q [0:NG];
  logic [WIDTH-1:0] a_q   [0:NG-1];
  logic [WIDTH-1:0] b_q   [0:NG-1];
  logic [WIDTH-1:0] s_q   [0:NG];
  logic             c_q   [0:NG];
  logic             m_q;

  logic [WIDTH-1:0] s_nx  [0:NG-1];
  logic             c_nx  [0:NG-1];
  logic             m_nx  [0:NG-1];

  logic en;

  assign en        = !vld_q[NG] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[NG];
  assign sum       = s_q[NG];
  assign cout      = c_q[NG];
  assign ovf       = c_q[NG] ^ m_q;

  genvar k;
  generate
    for (k = 0; k < NG; k++) begin : g_stage
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP:0]   c;
      logic [WIDTH-1:0] sn;

      assign g = a_q[k][k*GROUP +: GROUP]
               & b_q[k][k*GROUP +: GROUP];
      assign p = a_q[k][k*GROUP +: GROUP]
               ^ b_q[k][k*GROUP +: GROUP];

      // Flat lookahead: every carry from g, p and the group carry-in.
      always_comb begin
        logic t;
        t    = 1'b0;
        c    = '0;
        c[0] = c_q[k];
        for (int i = 0; i < GROUP; i++) begin
          t = c_q[k];
          for (int m = 0; m <= i; m++)
            t = t & p[m];
          c[i+1] = t;
          for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++)
              t = t & p[m];
            c[i+1] = c[i+1] | t;
          end
        end
      end

      // Merge this group's sum bits into the forwarded result.
      always_comb begin
        sn = s_q[k];
        sn[k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
      end

      assign s_nx[k] = sn;
      assign c_nx[k] = c[GROUP];
      assign m_nx[k] = c[GROUP-1];
    end
  endgenerate

  // Capture conditioned operands and advance all stages together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NG; i++) begin
        vld_q[i] <= 1'b0;
        s_q[i]   <= '0;
        c_q[i]   <= 1'b0;
      end
      for (int i = 0; i < NG; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      m_q <= 1'b0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0] <= a;
        b_q[0] <= sub ? ~b : b;
        c_q[0] <= sub | cin;
        s_q[0] <= '0;
      end
      for (int i = 0; i < NG; i++) begin
        vld_q[i+1] <= vld_q[i];
        if (vld_q[i]) begin
          s_q[i+1] <= s_nx[i];
          c_q[i+1] <= c_nx[i];
        end
      end
      for (int i = 0; i < NG - 1; i++) begin
        if (vld_q[i]) begin
          a_q[i+1] <= a_q[i];
          b_q[i+1] <= b_q[i];
        end
      end
      if (vld_q[NG-1])
        m_q <= m_nx[NG-1];
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: 32/8 and 16/4 instances
// share stimulus and are checked against a reference model.
module tb_cla_pipe_adder;

  localparam int NG = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, sub, cin, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_lat;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [15:0] s16;
    logic        c16;
    logic        o16;
    int          acc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready16),
    .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Modular add of w-bit operands; returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w,
                                        input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic s,
                                        input logic ci);
    longint unsigned mask, av, bv, t, ss;
    logic co, ov, sa, sb, sr;
    mask = (64'd1 << w) - 1;
    av = 64'(x) & mask;
    bv = (s ? ~64'(y) : 64'(y)) & mask;
    t  = av + bv + (s ? 64'd1 : 64'(ci));
    ss = t & mask;
    co = ((t >> w) & 1) != 0;
    sa = ((av >> (w - 1)) & 1) != 0;
    sb = ((bv >> (w - 1)) & 1) != 0;
    sr = ((ss >> (w - 1)) & 1) != 0;
    ov = (sa == sb) && (sr != sa);
    return {ov, co, ss[31:0]};
  endfunction

  task automatic cycle(input bit v,
                       input logic [31:0] xa,
                       input logic [31:0] xb,
                       input bit xs,
                       input bit xc,
                       input bit ordy,
                       output bit took);
    exp_t        e;
    logic [33:0] r, r16;
    bit          hp, ev;
    logic [31:0] hs;
    in_valid  = v;
    a         = xa;
    b         = xb;
    sub       = xs;
    cin       = xc;
    out_ready = ordy;
    #1;
    took = 1'b0;
    check("in_ready", in_ready, !out_valid || ordy);
    check("in_ready16", in_ready16, !out_valid || ordy);
    if (chk_lat) begin
      ev = 1'b0;
      if (q.size() > 0)
        ev = (cyc - q[0].acc) >= NG;
      check("vld", out_valid, ev);
      check("vld16", out_valid16, ev);
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spur", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("sum", sum, e.s);
        check("cout", cout, e.c);
        check("ovf", ovf, e.o);
        check("sum16", sum16, e.s16);
        check("cout16", cout16, e.c16);
        check("ovf16", ovf16, e.o16);
        if (chk_lat)
          check("lat", cyc - e.acc, NG);
      end
    end
    if (v && in_ready) begin
      r   = model(32, xa, xb, xs, xc);
      r16 = model(16, xa, xb, xs, xc);
      e.s   = r[31:0];
      e.c   = r[32];
      e.o   = r[33];
      e.s16 = r16[15:0];
      e.c16 = r16[32];
      e.o16 = r16[33];
      e.acc = cyc + 1;
      q.push_back(e);
      took = 1'b1;
    end
    hp = out_valid && !ordy;
    hs = sum;
    @(posedge clk);
    cyc++;
    #1;
    if (hp) begin
      check("hold_vld", out_valid, 1'b1);
      check("hold_sum", sum, hs);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    check("rst_vld", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_vld16", out_valid16, 1'b0);
    check("rst_sum16", sum16, 16'h0);
    check("rst_rdy", in_ready, 1'b1);
  endtask

  task automatic drain();
    bit t;
    for (int k = 0; k < 30 && q.size() > 0; k++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, t);
    check("drain", q.size(), 0);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int k = 0; k < n; k++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    do_reset();

    cycle(1'b1, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 1'b1, t);
    check("t1_took", t, 1'b1);
    drain();

    cycle(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1, t);
    cycle(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, t);
    cycle(1'b1, 32'h5, 32'h7, 1'b1, 1'b0, 1'b1, t);
    cycle(1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, t);
    drain();

    for (int i = 0; i < 8; i++)
      cycle(1'b1, $urandom, $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1, t);
    drain();

    chk_lat = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      cycle(1'b1, $urandom, $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            !(k >= 5 && k <= 7), t);
      if (t)
        n++;
    end
    check("bp_sent", n, 6);
    drain();

    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b1, t);
    do_reset();
    idle(10);
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1, t);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's fixed 8-bit combinational CLA.
- Operand width is split into GROUP-bit lookahead groups. One group resolves per pipeline stage, with the group carry registered between stages.
- Valid/ready handshake on both sides, so it drops into the neuron MAC datapath without extra glue.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of GROUP.
- GROUP, 8, lookahead group width in bits; legal values 4 or 8.
- NG (derived), WIDTH/GROUP, number of groups = pipeline depth; not user-set.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept an operand beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1)
- cin  in  1  carry-in for add mode; ignored when sub=1
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits, carries, and data registers clear to 0. Outputs read out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the cycle after reset deasserts. Reset mid-flight discards every in-flight beat; no partial result emerges.
- Operand conditioning at capture: bx = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (k = 0..NG-1) resolves group k:
  - per-bit G = a & bx and P = a ^ bx;
  - group carries use full lookahead from the registered carry-in: C[i+1] = G[i] | P[i]&C[i], expanded flat;
  - sum bits = P ^ C;
  - group carry-out registered into stage k+1.
- Data skew:
  - operand bits of groups above k are delayed alongside the beat;
  - completed sum groups are carried forward so all WIDTH bits align at the output register.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NG, assuming no stalls. Throughput is 1 beat per cycle.
- Flow control is a single global enable: en = !out_valid | out_ready.
  - in_ready = en, combinational from out_ready and the output valid.
  - When en=0, every stage holds its contents; no bubbles are collapsed.
  - A beat is accepted only when in_valid & in_ready.
- Empty stages propagate valid=0. Data in invalid stages is don't-care, but sum/cout/ovf hold their last valid value while out_valid=0.
- Result bits:
  - cout = carry out of group NG-1;
  - ovf = carry into MSB XOR carry out of MSB.
- Simultaneous events:
  - output consumed and new input accepted in the same cycle proceed together, with no lost or duplicated beat;
  - rst overrides all handshakes.
- Wrap-around: all-ones + 1 gives sum=0 and cout=1. There is no saturation; results are modular 2^WIDTH.

Test Plan:
1. Reset, then a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept; sum=0x0000_0100, cout=0, ovf=0.
2. a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0. This exercises the carry rippling through all 4 registered group boundaries.
3. Signed and sub cases:
   - a=0x7FFF_FFFF + b=0x0000_0001 -> sum=0x8000_0000, ovf=1, cout=0;
   - sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
4. Back-to-back stream of 8 random beats, out_ready=1 -> 8 consecutive out_valid cycles, each result matching a reference model, in order.
5. Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 in those cycles; out_valid/sum stay stable; no beat is lost, duplicated, or reordered.
6. Reset mid-flight: assert rst with 3 beats in flight -> out_valid=0 the next cycle and no stale result emerges later. Repeat with GROUP=4, WIDTH=16 (NG=4), case 2 values truncated to 16 bits.
